// File: rtl/mdu_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package mdu_pkg;

   localparam int unsigned D_WIDTH_DEFAULT = 32;

   typedef enum logic [2:0] {
      OpMul    = 3'b000,
      OpMulh   = 3'b001,
      OpMulhsu = 3'b010,
      OpMulhu  = 3'b011,
      OpDiv    = 3'b100,
      OpDivu   = 3'b101,
      OpRem    = 3'b110,
      OpRemu   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// One iteration of unsigned shift-add multiply or restoring divide on a {hi, lo} pair.
module mdu_iter_core #(
   parameter int unsigned D_WIDTH = 32
) (
   input  logic               is_div,
   input  logic [D_WIDTH-1:0] operand,
   input  logic [D_WIDTH-1:0] hi,
   input  logic [D_WIDTH-1:0] lo,
   output logic [D_WIDTH-1:0] hi_next,
   output logic [D_WIDTH-1:0] lo_next
);

   logic [D_WIDTH:0] sum;
   logic [D_WIDTH:0] shifted;
   logic             fits;

   always_comb begin
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
      shifted = {hi, lo[D_WIDTH-1]};
      fits    = shifted >= {1'b0, operand};
      hi_next = '0;
      lo_next = '0;
      if (is_div) begin
         // Remainder stays below the divisor, so the subtracted value fits in D_WIDTH bits.
         hi_next = fits ? (shifted[D_WIDTH-1:0] - operand) : shifted[D_WIDTH-1:0];
         lo_next = {lo[D_WIDTH-2:0], fits};
      end else begin
         hi_next = sum[D_WIDTH:1];
         lo_next = {sum[0], lo[D_WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mdu_seq.sv
// Sequential RISC-V M-extension unit: one operand bit per cycle, signs fixed up on entry to DONE.
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int unsigned D_WIDTH = D_WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               Start,
   input  logic [2:0]         MDUControl,
   input  logic [D_WIDTH-1:0] SrcA,
   input  logic [D_WIDTH-1:0] SrcB,
   output logic               Busy,
   output logic               Done,
   output logic [D_WIDTH-1:0] MDUResult
);

   localparam int unsigned CW = $clog2(D_WIDTH);
   localparam logic [CW-1:0] CntLast = CW'(D_WIDTH - 1);

   mdu_state_e state_q, state_d;
   mdu_op_e    op_q, op_in;
   logic [CW-1:0]        cnt_q;
   logic [D_WIDTH-1:0]   b_q, hi_q, lo_q, result_q;
   logic                 neg_q;

   logic                 accept;
   logic                 a_signed, b_signed, sa, sb, neg_in;
   logic [D_WIDTH-1:0]   mag_a, mag_b;
   logic [D_WIDTH-1:0]   hi_n, lo_n, q_s, r_s, result_next;
   logic [2*D_WIDTH-1:0] prod, prod_s;

   assign op_in  = mdu_op_e'(MDUControl);
   assign accept = Start && (state_q != StRun);

   always_comb begin
      a_signed = (op_in == OpMulh) || (op_in == OpMulhsu) || (op_in == OpDiv) || (op_in == OpRem);
      b_signed = (op_in == OpMulh) || (op_in == OpDiv) || (op_in == OpRem);
      sa       = a_signed && SrcA[D_WIDTH-1];
      sb       = b_signed && SrcB[D_WIDTH-1];
      mag_a    = sa ? -SrcA : SrcA;
      mag_b    = sb ? -SrcB : SrcB;
      neg_in   = 1'b0;
      unique case (op_in)
         OpMulh:   neg_in = sa ^ sb;
         OpMulhsu: neg_in = sa;
         // All-ones quotient on divide-by-zero must not be negated.
         OpDiv:    neg_in = (sa ^ sb) && (SrcB != '0);
         OpRem:    neg_in = sa;
         default:  neg_in = 1'b0;
      endcase
   end

   mdu_iter_core #(
      .D_WIDTH (D_WIDTH)
   ) u_core (
      .is_div  (op_q[2]),
      .operand (b_q),
      .hi      (hi_q),
      .lo      (lo_q),
      .hi_next (hi_n),
      .lo_next (lo_n)
   );

   always_comb begin
      prod        = {hi_n, lo_n};
      prod_s      = neg_q ? -prod : prod;
      q_s         = neg_q ? -lo_n : lo_n;
      r_s         = neg_q ? -hi_n : hi_n;
      result_next = '0;
      unique case (op_q)
         OpMul:                      result_next = prod_s[D_WIDTH-1:0];
         OpMulh, OpMulhsu, OpMulhu:  result_next = prod_s[2*D_WIDTH-1:D_WIDTH];
         OpDiv, OpDivu:              result_next = q_s;
         OpRem, OpRemu:              result_next = r_s;
         default:                    result_next = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: state_d = accept ? StRun : StIdle;
         StRun:          state_d = (cnt_q == '0) ? StDone : StRun;
         default:        state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         op_q     <= OpMul;
         cnt_q    <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q  <= op_in;
            b_q   <= mag_b;
            hi_q  <= '0;
            lo_q  <= mag_a;
            neg_q <= neg_in;
            cnt_q <= CntLast;
         end else if (state_q == StRun) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) begin
               result_q <= result_next;
            end
         end
      end
   end

   assign Busy      = (state_q == StRun);
   assign Done      = (state_q == StDone);
   assign MDUResult = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq with hand-computed expected results.
module tb_mdu_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        Start = 1'b0;
   logic [2:0]  MDUControl = 3'b000;
   logic [31:0] SrcA = '0;
   logic [31:0] SrcB = '0;
   logic        Busy, Done;
   logic [31:0] MDUResult;

   int n_vec = 0;
   int n_err = 0;

   mdu_seq #(
      .D_WIDTH (32)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Start      (Start),
      .MDUControl (MDUControl),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .Busy       (Busy),
      .Done       (Done),
      .MDUResult  (MDUResult)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Samples on falling edges until Done; lat counts samples, busy counts RUN samples.
   task automatic wait_done(output int lat, output int busy);
      bit seen;
      seen = 1'b0;
      lat  = 0;
      busy = 0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if (Done) seen = 1'b1;
         else if (Busy) busy++;
      end
   endtask

   task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      Start      = 1'b1;
      MDUControl = op;
      SrcA       = a;
      SrcB       = b;
      @(posedge clk);
      #1;
      Start = 1'b0;
      SrcA  = ~a;
      SrcB  = b + 32'd3;
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int lat, busy;
      launch(op, a, b);
      wait_done(lat, busy);
      check({tag, "_lat"}, lat, 33);
      check({tag, "_busy"}, busy, 32);
      check({tag, "_res"}, MDUResult, exp);
      @(negedge clk);
      check({tag, "_hold"}, {Done, Busy, MDUResult[29:0]}, {2'b00, exp[29:0]});
   endtask

   initial begin
      int lat, busy, total, pulses;

      #2;
      check("rst_busy", {31'd0, Busy}, 32'd0);
      check("rst_done", {31'd0, Done}, 32'd0);
      check("rst_res", MDUResult, 32'd0);
      #10 rst_n = 1'b1;

      run_op("mul_7x6",     3'b000, 32'd7,        32'd6,        32'd42);
      run_op("mul_neg",     3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1);
      run_op("mulh_min",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000);
      run_op("mulhu_max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      run_op("mulhsu_neg",  3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF);
      run_op("div_m7_2",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
      run_op("rem_m7_2",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
      run_op("rem_7_m2",    3'b110, 32'd7,        32'hFFFFFFFE, 32'd1);
      run_op("divu_100_7",  3'b101, 32'd100,      32'd7,        32'd14);
      run_op("remu_100_7",  3'b111, 32'd100,      32'd7,        32'd2);
      run_op("divu_by0",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF);
      run_op("div_neg_by0", 3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF);
      run_op("rem_neg_by0", 3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9);
      run_op("rem_ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0);
      run_op("div_ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);

      // Start pulse mid-RUN with other operands must be ignored.
      launch(3'b101, 32'd100, 32'd7);
      repeat (5) @(negedge clk);
      Start = 1'b1; MDUControl = 3'b000; SrcA = 32'd2; SrcB = 32'd3;
      @(negedge clk);
      Start = 1'b0;
      wait_done(lat, busy);
      total = lat + 6;
      check("glitch_lat", total, 33);
      check("glitch_res", MDUResult, 32'd14);

      // Back-to-back: Start held during the DONE cycle.
      launch(3'b000, 32'd7, 32'd6);
      wait_done(lat, busy);
      check("b2b1_lat", lat, 33);
      check("b2b1_res", MDUResult, 32'd42);
      Start = 1'b1; MDUControl = 3'b000; SrcA = 32'd9; SrcB = 32'd9;
      @(posedge clk);
      #1 Start = 1'b0;
      wait_done(lat, busy);
      check("b2b2_lat", lat, 33);
      check("b2b2_busy", busy, 32);
      check("b2b2_res", MDUResult, 32'd81);

      // Reset during RUN aborts the operation.
      launch(3'b100, 32'd100, 32'd7);
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, Busy}, 32'd0);
      check("abort_done", {31'd0, Done}, 32'd0);
      check("abort_res", MDUResult, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (Done || Busy) pulses++;
      end
      check("abort_quiet", pulses, 0);

      // First Start after reset release is accepted on the first rising edge.
      @(posedge clk);
      #2 rst_n = 1'b0;
      #4 rst_n = 1'b1;
      run_op("post_rst", 3'b111, 32'd17, 32'd5, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
